// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse parameter register block: address map, frame constants,
// receiver FSM encoding and the parameter record with its power-on values.
package pulse_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] COMMIT_ADDR = 8'h7F;

  localparam logic [3:0] ADDR_PER    = 4'h0;
  localparam logic [3:0] ADDR_P1WID  = 4'h1;
  localparam logic [3:0] ADDR_DEL    = 4'h2;
  localparam logic [3:0] ADDR_P2WID  = 4'h3;
  localparam logic [3:0] ADDR_P1WID2 = 4'h4;
  localparam logic [3:0] ADDR_DEL2   = 4'h5;
  localparam logic [3:0] ADDR_P2WID2 = 4'h6;
  localparam logic [3:0] ADDR_P1ST2  = 4'h7;
  localparam logic [3:0] ADDR_NUT_W  = 4'h8;
  localparam logic [3:0] ADDR_NUT_D  = 4'h9;
  localparam logic [3:0] ADDR_PR_ATT = 4'hA;
  localparam logic [3:0] ADDR_CP     = 4'hB;
  localparam logic [3:0] ADDR_P_BL   = 4'hC;
  localparam logic [3:0] ADDR_BL     = 4'hD;
  localparam logic [7:0] ADDR_MAX    = 8'h0D;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_CSUM} rx_state_t;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [15:0] p1wid2;
    logic [15:0] del2;
    logic [15:0] p2wid2;
    logic [15:0] p1st2;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [6:0]  pr_att;
    logic        cp;
    logic [7:0]  p_bl;
    logic        bl;
  } params_t;

  localparam params_t PARAM_RST = '{
    per:    32'd10000,
    p1wid:  16'd20,
    del:    16'd200,
    p2wid:  16'd40,
    p1wid2: 16'd0,
    del2:   16'd0,
    p2wid2: 16'd0,
    p1st2:  16'd0,
    nut_w:  8'd0,
    nut_d:  16'd0,
    pr_att: 7'd127,
    cp:     1'b1,
    p_bl:   8'd10,
    bl:     1'b0
  };

  // Each field keeps only the low bits of the 32-bit frame payload.
  function automatic params_t apply_write(params_t p, logic [3:0] a, logic [31:0] d);
    params_t r;
    r = p;
    case (a)
      ADDR_PER:    r.per    = d;
      ADDR_P1WID:  r.p1wid  = d[15:0];
      ADDR_DEL:    r.del    = d[15:0];
      ADDR_P2WID:  r.p2wid  = d[15:0];
      ADDR_P1WID2: r.p1wid2 = d[15:0];
      ADDR_DEL2:   r.del2   = d[15:0];
      ADDR_P2WID2: r.p2wid2 = d[15:0];
      ADDR_P1ST2:  r.p1st2  = d[15:0];
      ADDR_NUT_W:  r.nut_w  = d[7:0];
      ADDR_NUT_D:  r.nut_d  = d[15:0];
      ADDR_PR_ATT: r.pr_att = d[6:0];
      ADDR_CP:     r.cp     = d[0];
      ADDR_P_BL:   r.p_bl   = d[7:0];
      ADDR_BL:     r.bl     = d[0];
      default:     r = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pulse_param_regs_if.sv
// Byte stream from the UART receiver into the parameter register block.
interface pulse_param_regs_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, rx_valid);
  modport slave  (input  rx_data, rx_valid);
endinterface

// File: rtl/param_frame_rx.sv
// Frame decoder: SYNC, ADDR, 4 little-endian data bytes, XOR checksum, with inter-byte timeout.
// Emits one-cycle registered write / commit / error pulses.
module param_frame_rx #(
  parameter logic [7:0] SYNC_BYTE   = pulse_pkg::SYNC_BYTE,
  parameter logic [7:0] COMMIT_ADDR = pulse_pkg::COMMIT_ADDR,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        commit,
  output logic        err
);
  import pulse_pkg::*;

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);

  rx_state_t     state;
  logic [7:0]    addr;
  logic [7:0]    csum;
  logic [31:0]   data;
  logic [1:0]    idx;
  logic [CW-1:0] tcnt;

  assign wr_addr = addr[3:0];
  assign wr_data = data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      addr   <= '0;
      csum   <= '0;
      data   <= '0;
      idx    <= '0;
      tcnt   <= '0;
      wr_en  <= 1'b0;
      commit <= 1'b0;
      err    <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      commit <= 1'b0;
      err    <= 1'b0;
      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (rx_valid) begin
        tcnt <= '0;
        case (state)
          ST_IDLE: if (rx_data == SYNC_BYTE) state <= ST_ADDR;
          ST_ADDR: begin
            addr  <= rx_data;
            csum  <= rx_data;
            idx   <= '0;
            state <= ST_DATA;
          end
          ST_DATA: begin
            data <= {rx_data, data[31:8]};
            csum <= csum ^ rx_data;
            idx  <= idx + 2'd1;
            if (idx == 2'd3) state <= ST_CSUM;
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            if (rx_data != csum)          err    <= 1'b1;
            else if (addr <= ADDR_MAX)    wr_en  <= 1'b1;
            else if (addr == COMMIT_ADDR) commit <= 1'b1;
            else                          err    <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (tcnt == T_LAST) begin
          state <= ST_IDLE;
          tcnt  <= '0;
          err   <= 1'b1;
        end else begin
          tcnt <= tcnt + CW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pulse_param_regs.sv
// Shadow/active parameter banks for the pulse sequencer; a commit frame swaps all shadows
// into the active outputs in a single cycle.
module pulse_param_regs #(
  parameter logic [7:0] SYNC_BYTE   = pulse_pkg::SYNC_BYTE,
  parameter int         TIMEOUT_CYC = 500000,
  parameter logic [7:0] COMMIT_ADDR = pulse_pkg::COMMIT_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  pulse_param_regs_if.slave rx,
  output logic [31:0]       per,
  output logic [15:0]       p1wid,
  output logic [15:0]       del,
  output logic [15:0]       p2wid,
  output logic [15:0]       p1wid2,
  output logic [15:0]       del2,
  output logic [15:0]       p2wid2,
  output logic [15:0]       p1st2,
  output logic [15:0]       nut_d,
  output logic [7:0]        nut_w,
  output logic [7:0]        p_bl,
  output logic [6:0]        pr_att,
  output logic              cp,
  output logic              bl,
  output logic              param_update,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [7:0]        err_count
);
  import pulse_pkg::*;

  logic        wr_en, commit, err;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  params_t     shadow, active;

  param_frame_rx #(
    .SYNC_BYTE   (SYNC_BYTE),
    .COMMIT_ADDR (COMMIT_ADDR),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx.rx_data),
    .rx_valid (rx.rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .commit   (commit),
    .err      (err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow       <= PARAM_RST;
      active       <= PARAM_RST;
      param_update <= 1'b0;
      err_count    <= '0;
    end else begin
      param_update <= commit;
      if (wr_en)  shadow <= apply_write(shadow, wr_addr, wr_data);
      if (commit) active <= shadow;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Decoder pulses are already registered, so these strobes come straight from flops.
  assign frame_ok  = wr_en | commit;
  assign frame_err = err;

  assign per    = active.per;
  assign p1wid  = active.p1wid;
  assign del    = active.del;
  assign p2wid  = active.p2wid;
  assign p1wid2 = active.p1wid2;
  assign del2   = active.del2;
  assign p2wid2 = active.p2wid2;
  assign p1st2  = active.p1st2;
  assign nut_w  = active.nut_w;
  assign nut_d  = active.nut_d;
  assign pr_att = active.pr_att;
  assign cp     = active.cp;
  assign p_bl   = active.p_bl;
  assign bl     = active.bl;

endmodule

// File: tb/tb_pulse_param_regs.sv
// Directed bench for pulse_param_regs: frame decode, commit, errors, timeout, reset, saturation.
module tb_pulse_param_regs;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  pulse_param_regs_if rx();

  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_d;
  logic [7:0]  nut_w, p_bl, err_count;
  logic [6:0]  pr_att;
  logic        cp, bl, param_update, frame_ok, frame_err;

  int n_chk = 0, n_pass = 0;
  int n_ok_seen = 0, n_err_seen = 0, n_multi = 0;

  pulse_param_regs #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .p1wid2(p1wid2), .del2(del2),
    .p2wid2(p2wid2), .p1st2(p1st2), .nut_d(nut_d), .nut_w(nut_w), .p_bl(p_bl),
    .pr_att(pr_att), .cp(cp), .bl(bl), .param_update(param_update),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_ok)  n_ok_seen++;
      if (frame_err) n_err_seen++;
      if ((int'(frame_ok) + int'(frame_err) + int'(param_update)) > 1) n_multi++;
    end
  end

  // Byte is sampled at the next rising edge; returns 1 time unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    rx.rx_data  = b;
    rx.rx_valid = 1'b1;
    @(posedge clk); #1;
    rx.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    send_byte(d[23:16]);
    send_byte(d[31:24]);
    send_byte(cs);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    n_chk++; if (per !== 32'd10000) $display("FAIL reset_per got %0d want 10000", per); else n_pass++;
    n_chk++; if (p1wid !== 16'd20 || del !== 16'd200 || p2wid !== 16'd40)
      $display("FAIL reset_timing got %0d/%0d/%0d want 20/200/40", p1wid, del, p2wid); else n_pass++;
    n_chk++; if (pr_att !== 7'd127 || cp !== 1'b1 || p_bl !== 8'd10 || bl !== 1'b0)
      $display("FAIL reset_misc got pr_att=%0d cp=%0d p_bl=%0d bl=%0d want 127/1/10/0", pr_att, cp, p_bl, bl); else n_pass++;
    n_chk++; if ({p1wid2, del2, p2wid2, p1st2, nut_d, nut_w} !== '0)
      $display("FAIL reset_zero_fields got nonzero"); else n_pass++;
    n_chk++; if ({frame_ok, frame_err, param_update} !== 3'b000 || err_count !== 8'd0)
      $display("FAIL reset_strobes got %b cnt=%0d want 000 cnt=0", {frame_ok, frame_err, param_update}, err_count); else n_pass++;
  endtask

  task automatic test_write_commit();
    send_frame(8'h00, 32'h000F4240, 8'h0D);
    n_chk++; if (frame_ok !== 1'b1 || frame_err !== 1'b0)
      $display("FAIL wr_frame_ok got ok=%b err=%b want 1/0", frame_ok, frame_err); else n_pass++;
    n_chk++; if (per !== 32'd10000) $display("FAIL wr_shadow_only got %0d want 10000", per); else n_pass++;
    tick();
    n_chk++; if (frame_ok !== 1'b0 || param_update !== 1'b0 || per !== 32'd10000)
      $display("FAIL wr_after got ok=%b upd=%b per=%0d want 0/0/10000", frame_ok, param_update, per); else n_pass++;
    send_frame(8'h7F, 32'h0, 8'h7F);
    n_chk++; if (frame_ok !== 1'b1 || param_update !== 1'b0 || per !== 32'd10000)
      $display("FAIL commit_n1 got ok=%b upd=%b per=%0d want 1/0/10000", frame_ok, param_update, per); else n_pass++;
    tick();
    n_chk++; if (param_update !== 1'b1 || frame_ok !== 1'b0 || per !== 32'd1000000)
      $display("FAIL commit_n2 got upd=%b ok=%b per=%0d want 1/0/1000000", param_update, frame_ok, per); else n_pass++;
    tick();
    n_chk++; if (param_update !== 1'b0) $display("FAIL commit_pulse_width got %b want 0", param_update); else n_pass++;
  endtask

  task automatic test_bad_csum();
    send_frame(8'h01, 32'h00000064, 8'h00);
    n_chk++; if (frame_err !== 1'b1 || frame_ok !== 1'b0)
      $display("FAIL badcs_strobe got err=%b ok=%b want 1/0", frame_err, frame_ok); else n_pass++;
    tick();
    n_chk++; if (err_count !== 8'd1 || frame_err !== 1'b0)
      $display("FAIL badcs_count got %0d err=%b want 1/0", err_count, frame_err); else n_pass++;
    send_frame(8'h7F, 32'h0, 8'h7F);
    tick();
    n_chk++; if (p1wid !== 16'd20) $display("FAIL badcs_nowrite got %0d want 20", p1wid); else n_pass++;
  endtask

  task automatic test_timeout();
    int got;
    got = -1;
    send_byte(8'hA5);
    send_byte(8'h0B);
    for (int i = 1; i <= TO + 4; i++) begin
      tick();
      if (frame_err) begin got = i; break; end
    end
    n_chk++; if (got != TO) $display("FAIL timeout_cycle got %0d want %0d", got, TO); else n_pass++;
    tick();
    n_chk++; if (err_count !== 8'd2) $display("FAIL timeout_count got %0d want 2", err_count); else n_pass++;
    // Address byte lands exactly on the expiry cycle and must be accepted.
    send_byte(8'hA5);
    repeat (TO - 1) tick();
    send_byte(8'h0B);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h0B);
    n_chk++; if (frame_ok !== 1'b1) $display("FAIL timeout_edge_ok got %b want 1", frame_ok); else n_pass++;
    tick();
    n_chk++; if (err_count !== 8'd2) $display("FAIL timeout_edge_count got %0d want 2", err_count); else n_pass++;
    send_frame(8'h7F, 32'h0, 8'h7F);
    tick();
    n_chk++; if (cp !== 1'b0) $display("FAIL timeout_cp got %b want 0", cp); else n_pass++;
  endtask

  task automatic test_truncation();
    send_frame(8'h0A, 32'h00000105, 8'h0E);
    send_frame(8'h7F, 32'h0, 8'h7F);
    tick();
    n_chk++; if (pr_att !== 7'h05) $display("FAIL trunc_pr_att1 got %h want 05", pr_att); else n_pass++;
    send_frame(8'h0A, 32'h000000FF, 8'hF5);
    send_frame(8'h0C, 32'h12345678, 8'h04);
    send_frame(8'h0D, 32'h00000001, 8'h0C);
    n_chk++; if (frame_ok !== 1'b1) $display("FAIL trunc_addr0d_ok got %b want 1", frame_ok); else n_pass++;
    send_frame(8'h7F, 32'h0, 8'h7F);
    tick();
    n_chk++; if (pr_att !== 7'h7F || p_bl !== 8'h78 || bl !== 1'b1)
      $display("FAIL trunc_values got pr_att=%h p_bl=%h bl=%b want 7f/78/1", pr_att, p_bl, bl); else n_pass++;
    send_frame(8'h7F, 32'h0, 8'h7F);
    tick();
    n_chk++; if (param_update !== 1'b1) $display("FAIL repeat_commit got %b want 1", param_update); else n_pass++;
    send_frame(8'h20, 32'h0, 8'h20);
    n_chk++; if (frame_err !== 1'b1) $display("FAIL unmapped20 got %b want 1", frame_err); else n_pass++;
    send_frame(8'h0E, 32'h0, 8'h0E);
    n_chk++; if (frame_err !== 1'b1) $display("FAIL unmapped0e got %b want 1", frame_err); else n_pass++;
    tick();
    n_chk++; if (err_count !== 8'd4) $display("FAIL unmapped_count got %0d want 4", err_count); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int ok0, err0;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h11);
    reset = 1'b1;
    #1;
    n_chk++; if (per !== 32'd10000 || pr_att !== 7'd127 || cp !== 1'b1 || bl !== 1'b0 || p_bl !== 8'd10)
      $display("FAIL midrst_async got per=%0d pr_att=%0d cp=%b bl=%b p_bl=%0d", per, pr_att, cp, bl, p_bl); else n_pass++;
    n_chk++; if (err_count !== 8'd0) $display("FAIL midrst_count got %0d want 0", err_count); else n_pass++;
    tick();
    reset = 1'b0;
    tick();
    ok0 = n_ok_seen; err0 = n_err_seen;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    repeat (4) tick();
    n_chk++; if (n_ok_seen != ok0 || n_err_seen != err0)
      $display("FAIL midrst_ignored got ok+%0d err+%0d want 0/0", n_ok_seen - ok0, n_err_seen - err0); else n_pass++;
    n_chk++; if (per !== 32'd10000) $display("FAIL midrst_per got %0d want 10000", per); else n_pass++;
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 255; i++) send_frame(8'h20, 32'h0, 8'h20);
    tick();
    n_chk++; if (err_count !== 8'd255) $display("FAIL sat_255 got %0d want 255", err_count); else n_pass++;
    send_frame(8'h20, 32'h0, 8'h20);
    tick();
    n_chk++; if (err_count !== 8'd255) $display("FAIL sat_hold got %0d want 255", err_count); else n_pass++;
  endtask

  initial begin
    rx.rx_data  = 8'h00;
    rx.rx_valid = 1'b0;
    test_reset();
    test_write_commit();
    test_bad_csum();
    test_timeout();
    test_truncation();
    test_reset_midframe();
    test_err_saturate();
    n_chk++; if (n_multi != 0) $display("FAIL strobe_exclusive got %0d overlaps want 0", n_multi); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench timeout");
  end

endmodule
